// File: rtl/fetch_pkg.sv
// Shared types for the ROM fetch stage: FSM state encoding and the fetched-word record.
package fetch_pkg;

  localparam int unsigned FETCH_DATA_WIDTH = 16;
  localparam int unsigned FETCH_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StErr
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] addr;
    logic [FETCH_DATA_WIDTH-1:0] data;
  } fetch_word_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selector: redirect, increment, wrap or hold, plus range check.
module fetch_pc_next #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORDS      = 5,
  parameter int unsigned WRAP_EN    = 0
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] pc_next_o,
  output logic                  at_last_o,
  output logic                  target_oob_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   WordCount = (ADDR_WIDTH + 1)'(WORDS);

  logic [ADDR_WIDTH-1:0] target;

  assign at_last_o = (pc_i == LastAddr);

  // Range check applies to the address that would be fetched next.
  assign target       = redirect_i ? redirect_addr_i : pc_i;
  assign target_oob_o = ({1'b0, target} >= WordCount);

  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = redirect_addr_i;
    end else if (advance_i) begin
      if (!at_last_o) begin
        pc_next_o = pc_i + ADDR_WIDTH'(1);
      end else if (WRAP_EN != 0) begin
        pc_next_o = '0;
      end
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Fetch stage in front of a combinational ROM: owns the PC and registers words for decode.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORDS      = 5,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned WRAP_EN    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  done_o,
  output logic                  error_o
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;

  logic load, accept, redirect, at_last, target_oob;

  // ERR ignores redirects so the PC and the error stay frozen until reset.
  assign redirect = redirect_valid_i && (state_q != StErr);
  assign accept   = valid_q && instr_ready_i;
  assign load     = (state_q == StRun) && en_i && (!valid_q || instr_ready_i) && !redirect_valid_i;

  fetch_pc_next #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORDS     (WORDS),
    .WRAP_EN   (WRAP_EN)
  ) u_pc_next (
    .pc_i           (pc_q),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr_i),
    .advance_i      (load),
    .pc_next_o      (pc_d),
    .at_last_o      (at_last),
    .target_oob_o   (target_oob)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (target_oob) state_d = StErr;
        end else if (en_i) begin
          state_d = target_oob ? StErr : StRun;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      StRun: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (target_oob) state_d = StErr;
        end else if (load) begin
          instr_d = rom_data_i;
          iaddr_d = pc_q;
          valid_d = 1'b1;
          if (at_last && (WRAP_EN == 0)) state_d = StDone;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      StDone: begin
        if (redirect) begin
          valid_d = 1'b0;
          state_d = target_oob ? StErr : StRun;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      StErr: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= ADDR_WIDTH'(RESET_ADDR);
      valid_q <= 1'b0;
      instr_q <= '0;
      iaddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
    end
  end

  assign rom_addr_o    = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_addr_o  = iaddr_q;
  assign done_o        = (state_q == StDone);
  assign error_o       = (state_q == StErr);

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench: a stop-at-end instance and a wrapping instance share stimulus and ROM image.
module tb_rom_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        ready;

  logic [7:0]  rom_addr, rom_addr_w;
  logic [15:0] rom_data, rom_data_w;
  logic        valid, valid_w;
  logic [15:0] instr, instr_w;
  logic [7:0]  iaddr, iaddr_w;
  logic        done, done_w;
  logic        error, error_w;

  logic [15:0] rom [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hdead;
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3333;
    rom[3] = 16'h4444;
    rom[4] = 16'h5555;
  end

  assign rom_data   = rom[rom_addr];
  assign rom_data_w = rom[rom_addr_w];

  rom_fetch_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .WORDS(5), .RESET_ADDR(0), .WRAP_EN(0)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .en_i            (en),
    .redirect_valid_i(redirect_valid),
    .redirect_addr_i (redirect_addr),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .instr_valid_o   (valid),
    .instr_ready_i   (ready),
    .instr_o         (instr),
    .instr_addr_o    (iaddr),
    .done_o          (done),
    .error_o         (error)
  );

  rom_fetch_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .WORDS(5), .RESET_ADDR(0), .WRAP_EN(1)
  ) dut_w (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .en_i            (en),
    .redirect_valid_i(redirect_valid),
    .redirect_addr_i (redirect_addr),
    .rom_addr_o      (rom_addr_w),
    .rom_data_i      (rom_data_w),
    .instr_valid_o   (valid_w),
    .instr_ready_i   (ready),
    .instr_o         (instr_w),
    .instr_addr_o    (iaddr_w),
    .done_o          (done_w),
    .error_o         (error_w)
  );

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00; ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({valid, instr, iaddr, done, error} !== {1'b0, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b i=%h a=%h d=%b e=%b, want all zero",
               valid, instr, iaddr, done, error);
    end
    tests++;
    if (rom_addr !== 8'h00) begin
      fails++;
      $display("FAIL reset_pc: got %h want 00", rom_addr);
    end
    step();
    tests++;
    if ({valid, done} !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_en: got v=%b d=%b want 0 0", valid, done);
    end
  endtask

  task automatic test_stream();
    fetch_word_t exp;
    do_reset();
    en = 1'b1; ready = 1'b1;
    step();
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_idle_to_run: valid got %b want 0", valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      exp.addr = 8'(i);
      exp.data = 16'h1111 * 16'(i + 1);
      tests++;
      if ({valid, iaddr, instr} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL stream_word%0d: got v=%b %h/%h want 1 %h/%h",
                 i, valid, instr, iaddr, exp.data, exp.addr);
      end
    end
    step();
    tests++;
    if ({done, valid, rom_addr} !== {1'b1, 1'b0, 8'h04}) begin
      fails++;
      $display("FAIL stream_done: got d=%b v=%b pc=%h want 1 0 04", done, valid, rom_addr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; ready = 1'b1;
    step();
    step();
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({valid, instr, iaddr, rom_addr} !== {1'b1, 16'h2222, 8'h01, 8'h02}) begin
        fails++;
        $display("FAIL hold_cycle%0d: got v=%b %h/%h pc=%h want 1 2222/01 pc=02",
                 i, valid, instr, iaddr, rom_addr);
      end
      step();
    end
    ready = 1'b1;
    step();
    tests++;
    if ({valid, instr, iaddr} !== {1'b1, 16'h3333, 8'h02}) begin
      fails++;
      $display("FAIL resume_3333: got v=%b %h/%h want 1 3333/02", valid, instr, iaddr);
    end
    step();
    tests++;
    if ({valid, instr, iaddr} !== {1'b1, 16'h4444, 8'h03}) begin
      fails++;
      $display("FAIL resume_4444: got v=%b %h/%h want 1 4444/03", valid, instr, iaddr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [7];
    exp_addr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1};
    do_reset();
    en = 1'b1; ready = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      tests++;
      if ({valid_w, iaddr_w, done_w} !== {1'b1, exp_addr[i], 1'b0}) begin
        fails++;
        $display("FAIL wrap_word%0d: got v=%b a=%h d=%b want 1 a=%h d=0",
                 i, valid_w, iaddr_w, done_w, exp_addr[i]);
      end
      tests++;
      if (instr_w !== rom[exp_addr[i]]) begin
        fails++;
        $display("FAIL wrap_data%0d: got %h want %h", i, instr_w, rom[exp_addr[i]]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1'b1; ready = 1'b1;
    step();
    step();
    step();
    ready = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 8'd3;
    step();
    tests++;
    if ({valid, rom_addr} !== {1'b0, 8'h03}) begin
      fails++;
      $display("FAIL redirect_flush: got v=%b pc=%h want 0 03", valid, rom_addr);
    end
    redirect_valid = 1'b0; ready = 1'b1;
    step();
    tests++;
    if ({valid, instr, iaddr} !== {1'b1, 16'h4444, 8'h03}) begin
      fails++;
      $display("FAIL redirect_first: got v=%b %h/%h want 1 4444/03", valid, instr, iaddr);
    end
    step();
    tests++;
    if ({valid, instr, iaddr} !== {1'b1, 16'h5555, 8'h04}) begin
      fails++;
      $display("FAIL redirect_second: got v=%b %h/%h want 1 5555/04", valid, instr, iaddr);
    end
    // From DONE a redirect resumes fetching.
    redirect_valid = 1'b1; redirect_addr = 8'd1;
    step();
    redirect_valid = 1'b0;
    step();
    tests++;
    if ({done, valid, instr, iaddr} !== {1'b0, 1'b1, 16'h2222, 8'h01}) begin
      fails++;
      $display("FAIL done_redirect: got d=%b v=%b %h/%h want 0 1 2222/01",
               done, valid, instr, iaddr);
    end
  endtask

  task automatic test_error();
    do_reset();
    en = 1'b1; ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_addr = 8'd7;
    step();
    tests++;
    if ({error, valid} !== 2'b10) begin
      fails++;
      $display("FAIL err_enter: got e=%b v=%b want 1 0", error, valid);
    end
    redirect_addr = 8'd2;
    step();
    redirect_valid = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    step();
    step();
    tests++;
    if ({error, valid, done} !== 3'b100) begin
      fails++;
      $display("FAIL err_sticky: got e=%b v=%b d=%b want 1 0 0", error, valid, done);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({error, valid} !== 2'b00) begin
      fails++;
      $display("FAIL err_reset_clear: got e=%b v=%b want 0 0", error, valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; ready = 1'b1;
    step();
    step();
    step();
    step();
    tests++;
    if ({rom_addr, valid, instr} !== {8'h03, 1'b1, 16'h3333}) begin
      fails++;
      $display("FAIL pre_reset_pc3: got pc=%h v=%b i=%h want 03 1 3333", rom_addr, valid, instr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({valid, instr, iaddr, rom_addr, done, error} !== {1'b0, 16'h0, 8'h0, 8'h0, 2'b00}) begin
      fails++;
      $display("FAIL async_clear: got v=%b i=%h a=%h pc=%h d=%b e=%b want all zero",
               valid, instr, iaddr, rom_addr, done, error);
    end
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    step();
    step();
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL restart_needs_en: valid got %b want 0", valid);
    end
    en = 1'b1;
    step();
    step();
    tests++;
    if ({valid, instr, iaddr} !== {1'b1, 16'h1111, 8'h00}) begin
      fails++;
      $display("FAIL restart_first: got v=%b %h/%h want 1 1111/00", valid, instr, iaddr);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00; ready = 1'b0;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_redirect();
    test_error();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
Sequential fetch stage directly upstream of the rom block. It owns the program counter, drives the ROM's address input and captures the ROM's combinational read data into an output register. It presents fetched words to the consumer (decode) over a valid/ready handshake. Supports redirect (branch/jump), pause, end-of-program stop or wrap, and out-of-range error detection.

Parameters:
DATA_WIDTH, 16, width of a ROM word; must match the rom instance.
ADDR_WIDTH, 8, width of the ROM address; must match the rom instance.
WORDS, 5, number of valid ROM words; legal addresses are 0..WORDS-1.
RESET_ADDR, 0, program counter value after reset.
WRAP_EN, 0, 1 = wrap the PC from WORDS-1 to 0; 0 = stop after the last word.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous active-low reset.
en_i  in  1  run enable; 0 pauses fetching.
redirect_valid_i  in  1  load a new PC this cycle.
redirect_addr_i  in  ADDR_WIDTH  target PC for the redirect.
rom_addr_o  out  ADDR_WIDTH  to rom addr_i; combinationally equal to the PC.
rom_data_i  in  DATA_WIDTH  from rom data_o; combinational read of rom_addr_o.
instr_valid_o  out  1  instr_o and instr_addr_o hold a fetched word.
instr_ready_i  in  1  consumer accepts the word this cycle.
instr_o  out  DATA_WIDTH  fetched word.
instr_addr_o  out  ADDR_WIDTH  address the word was fetched from.
done_o  out  1  high while in the DONE state.
error_o  out  1  sticky out-of-range error.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_ni=0 forces all state immediately, independent of clk_i.
- Reset values: state=IDLE, pc=RESET_ADDR, instr_valid_o=0, instr_o=0, instr_addr_o=0, done_o=0, error_o=0.
- rom_addr_o is always equal to pc. The ROM read is combinational, so no wait state is needed.
- load = (state==RUN) && en_i && (!instr_valid_o || instr_ready_i) && !redirect_valid_i.
- Handshake: a word transfers on any edge where instr_valid_o && instr_ready_i. While instr_valid_o=1 and instr_ready_i=0, instr_o and instr_addr_o are held stable.
- Latency: a PC value appears on instr_o at the edge after it is presented, giving 1 word/cycle throughput with ready held high.
- States:
  - IDLE: no fetch. en_i=1 -> RUN, or -> ERR if pc>=WORDS.
  - RUN: on load, instr_o<=rom_data_i, instr_addr_o<=pc, instr_valid_o<=1. The PC then updates as follows:
    - if pc==WORDS-1 and WRAP_EN=1: pc<=0.
    - if pc==WORDS-1 and WRAP_EN=0: go to DONE, pc holds.
    - otherwise: pc<=pc+1 (ADDR_WIDTH arithmetic).
    - Consumed with no load: instr_valid_o<=0.
    - en_i=0: no new loads; a held word stays until consumed.
  - DONE: done_o=1, no fetch. The pending word is still delivered, then instr_valid_o<=0.
  - ERR: error_o=1, instr_valid_o<=0, no fetch. Sticky until reset.
- Redirect (redirect_valid_i=1) has the highest priority over load in every state except ERR:
  - pc<=redirect_addr_i, and instr_valid_o<=0, which flushes any held word whether or not it was accepted that cycle.
  - redirect_addr_i>=WORDS -> ERR.
  - In DONE, a redirect returns to RUN.
  - In IDLE, a redirect updates pc and the state stays IDLE.
- Simultaneous redirect + accept: the consumer's transfer counts; no new word is loaded that cycle.
- Reset asserted mid-run: all state is cleared at once. After release, the fetch restarts from RESET_ADDR and needs en_i again.

Decomposition:
- Package fetch_pkg: state enum (IDLE, RUN, DONE, ERR) and a fetch_word_t struct {addr, data}, parameterised via localparam widths matching the rom block defaults.
- One natural sub-module: fetch_pc_next, a combinational next-PC selector covering redirect, increment, wrap, hold and range check. The output register and FSM stay in the top.

Test Plan:
- ROM preloaded 0x1111,0x2222,0x3333,0x4444,0x5555; reset, en_i=1, ready=1 -> instr_o 0x1111..0x5555 on 5 consecutive cycles, instr_addr_o 0..4, then done_o=1 and instr_valid_o=0.
- Same, with ready=0 for 3 cycles while holding 0x2222 -> instr_o/instr_addr_o stable at 0x2222/1, rom_addr_o=2; after ready returns, 0x3333 follows with no word dropped or duplicated.
- WRAP_EN=1, ready=1 for 7 cycles -> addresses 0,1,2,3,4,0,1, with done_o never asserted.
- Redirect to 3 while 0x2222 is pending -> instr_valid_o=0 for one cycle, then 0x4444/3, then 0x5555/4.
- Redirect to 7 (>=WORDS) -> error_o=1 and instr_valid_o=0, staying that way through later redirects and en_i toggling until rst_ni=0 clears it.
- rst_ni pulsed low mid-cycle at pc=3 -> outputs clear immediately without a clock edge; after release plus en_i, fetch restarts with 0x1111/0.
